// File: rtl/lcd_seq_ctrl_pkg.sv
// Shared types and constants for the HD44780 LCD sequencer: FSM states,
// command bytes and the fixed power-on init sequence.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_PWRUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_LINE0     = 8'h80;
  localparam logic [7:0] CMD_LINE1     = 8'hC0;

  localparam int unsigned INIT_LEN = 6;
  localparam int unsigned INIT_IW  = $clog2(INIT_LEN);
  localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{
    CMD_FUNC_8B2L, CMD_FUNC_8B2L, CMD_FUNC_8B2L, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
  };

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// Write handshake between the result formatter (master) and the LCD
// sequencer (slave).
interface lcd_seq_ctrl_if;
  logic       req;
  logic       rs;
  logic [7:0] data;
  logic       ready;

  modport master (output req, rs, data, input ready);
  modport slave  (input req, rs, data, output ready);
endinterface

// File: rtl/lcd_seq_ctrl_delay_cnt.sv
// Loadable down-counter shared by every timed LCD state; done_o flags the
// final cycle of a loaded interval until the next load.
module lcd_delay_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic         busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= val_i;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// HD44780 16x2 LCD sequencer: power-up wait, init sequence, then one
// handshaked write at a time. Optional cursor wrap via `LCD_WRAP_EN.
module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 750000,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned E_CYC     = 12,
  parameter int unsigned CMD_CYC   = 2000,
  parameter int unsigned CLR_CYC   = 82000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  lcd_seq_ctrl_if.slave  host,
  output logic           init_done_o,
  output logic           lcd_e_o,
  output logic           lcd_rs_o,
  output logic           lcd_rw_o,
  output logic           lcd_on_o,
  output logic           lcd_blon_o,
  output logic [7:0]     lcd_data_o
);

  localparam int unsigned MAX_CYC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC);

  lcd_state_e         state_q, state_d;
  logic [INIT_IW-1:0] idx_q, idx_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               e_q, ready_q, init_done_q, on_q;
  logic               ld, done, start, st_rs;
  logic [CW-1:0]      ld_val;
  logic [7:0]         st_data;
`ifdef LCD_WRAP_EN
  logic               line_q, line_d, pend_q, pend_d;
  logic [3:0]         col_q, col_d;
  logic [7:0]         wcmd_q, wcmd_d;
`endif

  lcd_delay_cnt #(.W(CW)) u_dly (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ld),
    .val_i  (ld_val),
    .done_o (done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ld      = 1'b0;
    ld_val  = '0;
    start   = 1'b0;
    st_rs   = 1'b0;
    st_data = '0;
`ifdef LCD_WRAP_EN
    line_d  = line_q;
    col_d   = col_q;
    pend_d  = pend_q;
    wcmd_d  = wcmd_q;
`endif
    case (state_q)
      ST_RST: begin
        state_d = ST_PWRUP;
        ld      = 1'b1;
        ld_val  = CW'(PWRUP_CYC - 1);
      end
      ST_PWRUP: if (done) begin
        start   = 1'b1;
        st_data = INIT_SEQ[0];
        idx_d   = '0;
      end
      ST_SETUP: if (done) begin
        state_d = ST_PULSE;
        ld      = 1'b1;
        ld_val  = CW'(E_CYC - 1);
      end
      ST_PULSE: if (done) begin
        state_d = ST_HOLD;
        ld      = 1'b1;
        ld_val  = CW'(SETUP_CYC - 1);
      end
      ST_HOLD: if (done) begin
        state_d = ST_WAIT;
        ld      = 1'b1;
        ld_val  = is_clr_home(rs_q, data_q) ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);
      end
      ST_WAIT: if (done) begin
        if (!init_done_q) begin
          if (idx_q == INIT_IW'(INIT_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            start   = 1'b1;
            st_data = INIT_SEQ[idx_q + 1'b1];
          end
        end
`ifdef LCD_WRAP_EN
        else if (pend_q) begin
          start   = 1'b1;
          st_data = wcmd_q;
          pend_d  = 1'b0;
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: if (host.req) begin
        start   = 1'b1;
        st_rs   = host.rs;
        st_data = host.data;
      end
      default: state_d = ST_RST;
    endcase

    // Every write, whether init, host or autonomous, enters through SETUP.
    if (start) begin
      state_d = ST_SETUP;
      ld      = 1'b1;
      ld_val  = CW'(SETUP_CYC - 1);
      rs_d    = st_rs;
      data_d  = st_data;
`ifdef LCD_WRAP_EN
      if (st_rs) begin
        col_d = col_q + 1'b1;
        if (col_q == 4'hF) begin
          pend_d = 1'b1;
          wcmd_d = line_q ? CMD_LINE0 : CMD_LINE1;
        end
      end else if (is_clr_home(st_rs, st_data)) begin
        line_d = 1'b0;
        col_d  = '0;
      end else if (st_data[7]) begin
        line_d = st_data[6];
        col_d  = st_data[3:0];
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RST;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      e_q         <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
`ifdef LCD_WRAP_EN
      line_q      <= 1'b0;
      col_q       <= '0;
      pend_q      <= 1'b0;
      wcmd_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      e_q         <= (state_d == ST_PULSE);
      ready_q     <= (state_d == ST_IDLE);
      init_done_q <= init_done_q | (state_d == ST_IDLE);
      on_q        <= 1'b1;
`ifdef LCD_WRAP_EN
      line_q      <= line_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
      wcmd_q      <= wcmd_d;
`endif
    end
  end

  assign host.ready  = ready_q;
  assign init_done_o = init_done_q;
  assign lcd_e_o     = e_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_on_o    = on_q;
  assign lcd_blon_o  = on_q;
  assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Scoreboard bench for lcd_seq_ctrl with shortened timing parameters.
module tb_lcd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done, lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] lcd_data;
  int         checks = 0;
  int         fails  = 0;
  int         cyc    = -1;

  lcd_seq_ctrl_if host ();

  lcd_seq_ctrl #(
    .PWRUP_CYC(100), .SETUP_CYC(2), .E_CYC(4), .CMD_CYC(20), .CLR_CYC(50)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .host        (host),
    .init_done_o (init_done),
    .lcd_e_o     (lcd_e),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_on_o    (lcd_on),
    .lcd_blon_o  (lcd_blon),
    .lcd_data_o  (lcd_data)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first posedge that samples rst=0.
  always @(posedge clk) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int         init_cyc [6] = '{102, 130, 158, 186, 214, 272};
  logic [7:0] init_dat [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  logic e_prev = 1'b0;
  int   hi     = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      e_prev = 1'b0;
      hi     = 0;
    end else begin
      if (lcd_e && !e_prev) begin
        hi = 1;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got rs=%0b data=%02h at cycle %0d, required no pulse",
                   lcd_rs, lcd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({lcd_rs, lcd_data} !== {e.rs, e.data}) begin
            fails++;
            $display("FAIL pulse_value: got rs=%0b data=%02h, required rs=%0b data=%02h",
                     lcd_rs, lcd_data, e.rs, e.data);
          end
          checks++;
          if (cyc !== e.cyc) begin
            fails++;
            $display("FAIL pulse_cycle: got %0d, required %0d (data %02h)", cyc, e.cyc, e.data);
          end
        end
      end else if (lcd_e) begin
        hi++;
      end else if (e_prev) begin
        checks++;
        if (hi != 4) begin
          fails++;
          $display("FAIL pulse_width: got %0d cycles, required 4", hi);
        end
      end
      e_prev = lcd_e;
    end
  end

  task automatic push_init;
    for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, init_dat[i], init_cyc[i]});
  endtask

  // Drives one request at a ready negedge; returns cycles ready stayed low.
  task automatic do_write(input logic rs, input logic [7:0] data, output int low);
    host.req  = 1'b1;
    host.rs   = rs;
    host.data = data;
    exp_q.push_back('{rs, data, cyc + 3});
    @(negedge clk);
    host.req = 1'b0;
    low = 0;
    while (host.ready !== 1'b1 && low < 1000) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    host.req  = 1'b0;
    host.rs   = 1'b0;
    host.data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, host.ready, init_done, lcd_on, lcd_blon} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got e/rs/rw/rdy/done/on/blon=%07b, required 0000000",
               {lcd_e, lcd_rs, lcd_rw, host.ready, init_done, lcd_on, lcd_blon});
    end
    checks++;
    if (lcd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %02h, required 00", lcd_data);
    end
    push_init();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lcd_on, lcd_blon, host.ready, lcd_e} !== 4'b1100) begin
      fails++;
      $display("FAIL power_on: got on/blon/rdy/e=%04b, required 1100",
               {lcd_on, lcd_blon, host.ready, lcd_e});
    end
  endtask

  task automatic test_init;
    int t = 0;
    while (host.ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cyc !== 298) begin
      fails++;
      $display("FAIL init_ready_cycle: got %0d, required 298", cyc);
    end
    checks++;
    if (init_done !== 1'b1) begin
      fails++;
      $display("FAIL init_done: got %0b, required 1", init_done);
    end
    checks++;
    if ({lcd_rs, lcd_data} !== {1'b0, 8'h06}) begin
      fails++;
      $display("FAIL idle_hold: got rs=%0b data=%02h, required rs=0 data=06", lcd_rs, lcd_data);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL init_pulses: got %0d missing pulses, required 0", exp_q.size());
    end
  endtask

  task automatic test_data_write;
    int n, low;
    n         = cyc;
    host.req  = 1'b1;
    host.rs   = 1'b1;
    host.data = 8'h35;
    exp_q.push_back('{1'b1, 8'h35, n + 3});
    @(negedge clk);
    checks++;
    if (host.ready !== 1'b0) begin
      fails++;
      $display("FAIL write_ready_drop: got %0b, required 0", host.ready);
    end
    // Keep req asserted with a new byte; it must wait for ready.
    host.data = 8'h41;
    low = 1;
    while (low < 200) begin
      @(negedge clk);
      if (host.ready === 1'b1) break;
      low++;
    end
    checks++;
    if (low !== 28 || cyc !== n + 29) begin
      fails++;
      $display("FAIL write_busy: got %0d busy cycles ending at %0d, required 28 ending at %0d",
               low, cyc, n + 29);
    end
    exp_q.push_back('{1'b1, 8'h41, cyc + 3});
    @(negedge clk);
    host.req = 1'b0;
    checks++;
    if (host.ready !== 1'b0) begin
      fails++;
      $display("FAIL held_req_accept: got ready=%0b, required 0", host.ready);
    end
    low = 1;
    while (low < 200) begin
      @(negedge clk);
      if (host.ready === 1'b1) break;
      low++;
    end
    checks++;
    if (low !== 28) begin
      fails++;
      $display("FAIL held_write_busy: got %0d, required 28", low);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL write_pulses: got %0d missing pulses, required 0", exp_q.size());
    end
  endtask

  task automatic test_clear;
    int low;
    do_write(1'b0, 8'h01, low);
    checks++;
    if (low !== 58) begin
      fails++;
      $display("FAIL clear_busy: got %0d, required 58", low);
    end
    checks++;
    if ({lcd_rs, lcd_data} !== {1'b0, 8'h01}) begin
      fails++;
      $display("FAIL clear_hold: got rs=%0b data=%02h, required rs=0 data=01", lcd_rs, lcd_data);
    end
    do_write(1'b0, 8'h0C, low);
    checks++;
    if (low !== 28) begin
      fails++;
      $display("FAIL cmd_busy: got %0d, required 28", low);
    end
  endtask

`ifdef LCD_WRAP_EN
  task automatic test_wrap;
    int low, n, want;
    logic [7:0] ch;
    for (int i = 0; i < 32; i++) begin
      n    = cyc;
      ch   = 8'h41 + 8'(i % 26);
      want = 28;
      if (i == 15 || i == 31) begin
        exp_q.push_back('{1'b1, ch, n + 3});
        exp_q.push_back('{1'b0, (i == 15) ? 8'hC0 : 8'h80, n + 31});
        want = 56;
        host.req  = 1'b1;
        host.rs   = 1'b1;
        host.data = ch;
        @(negedge clk);
        host.req = 1'b0;
        low = 0;
        while (host.ready !== 1'b1 && low < 1000) begin
          low++;
          @(negedge clk);
        end
      end else begin
        do_write(1'b1, ch, low);
      end
      checks++;
      if (low !== want) begin
        fails++;
        $display("FAIL wrap_busy_%0d: got %0d, required %0d", i, low, want);
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    int t = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, init_dat[i], init_cyc[i]});
    rst = 1'b0;
    while (cyc !== 159 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (lcd_e !== 1'b1) begin
      fails++;
      $display("FAIL mid_pulse: got e=%0b at cycle %0d, required 1 at 159", lcd_e, cyc);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({lcd_e, init_done, host.ready, lcd_on} !== 4'b0000) begin
      fails++;
      $display("FAIL abort: got e/done/rdy/on=%04b, required 0000",
               {lcd_e, init_done, host.ready, lcd_on});
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL abort_pulses: got %0d missing pulses, required 0", exp_q.size());
    end
    push_init();
    rst = 1'b0;
    t   = 0;
    while (host.ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cyc !== 298 || init_done !== 1'b1) begin
      fails++;
      $display("FAIL rerun_init: got ready at %0d done=%0b, required 298 done=1", cyc, init_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rerun_pulses: got %0d missing pulses, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_clear();
`ifdef LCD_WRAP_EN
    test_wrap();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
